// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, default frame geometry and the
// parity helper that the TX bit sequencer also uses.
package uart_pkg;

    localparam int DEF_DATA_BITS  = 8;
    localparam int DEF_OVERSAMPLE = 16;
    localparam int PAR_W          = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_e;

    // XOR-reduce a zero-extended frame slice; callers compare against the odd/even setting.
    function automatic logic calc_parity(input logic [PAR_W-1:0] bits_v);
        calc_parity = ^bits_v;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle (high) level.
module uart_rx_sync (
    input  logic clk,
    input  logic arst_n,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;

    // Shift the raw line through two flops; both reset paths load the idle level.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sync_q <= 2'b11;
        end else if (rst) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], d_i};
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/uart_rx_deserializer.sv
// UART receive path: oversampled start detection, mid-bit sampling, LSB-first shift-in
// of one frame and parity/framing error flagging.
module uart_rx_deserializer
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEF_DATA_BITS,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter bit PARITY_EN  = 1'b1,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic                 clk,
    input  logic                 arst_n,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 busy,
    output logic                 parity_err,
    output logic                 frame_err
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(OVERSAMPLE - 1);
    localparam logic [TICK_W-1:0] TICK_ONE  = TICK_W'(1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

    logic                 rx_s;

    rx_state_e            state_q,      state_d;
    logic [TICK_W-1:0]    tick_cnt_q,   tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q,    bit_cnt_d;
    logic [DATA_BITS-1:0] shreg_q,      shreg_d;
    logic                 par_bit_q,    par_bit_d;
    logic [DATA_BITS-1:0] data_out_q,   data_out_d;
    logic                 data_valid_q, data_valid_d;
    logic                 busy_q,       busy_d;
    logic                 parity_err_q, parity_err_d;
    logic                 frame_err_q,  frame_err_d;

    uart_rx_sync u_sync (
        .clk    (clk),
        .arst_n (arst_n),
        .rst    (rst),
        .d_i    (rx_in),
        .q_o    (rx_s)
    );

    // Frame sequencing; everything advances only on oversample ticks.
    always_comb begin
        state_d      = state_q;
        tick_cnt_d   = tick_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shreg_d      = shreg_q;
        par_bit_d    = par_bit_q;
        data_out_d   = data_out_q;
        data_valid_d = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;

        if (sample_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (!rx_s) begin
                        state_d    = ST_START;
                        tick_cnt_d = '0;
                    end else begin
                        state_d    = ST_IDLE;
                    end
                end
                // Re-check the line half a bit in so short glitches are rejected.
                ST_START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d    = ST_DATA;
                            tick_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == TICK_END) begin
                        shreg_d    = {rx_s, shreg_q[DATA_BITS-1:1]};
                        tick_cnt_d = '0;
                        bit_cnt_d  = bit_cnt_q + BIT_ONE;
                        if (bit_cnt_q == BIT_LAST) begin
                            if (PARITY_EN) begin
                                state_d = ST_PARITY;
                            end else begin
                                state_d = ST_STOP;
                            end
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == TICK_END) begin
                        par_bit_d  = rx_s;
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                // Leave at mid-stop so a following start edge is caught without a gap.
                ST_STOP: begin
                    if (tick_cnt_q == TICK_END) begin
                        data_out_d   = shreg_q;
                        data_valid_d = 1'b1;
                        frame_err_d  = ~rx_s;
                        parity_err_d = PARITY_EN &
                                       (calc_parity(PAR_W'({shreg_q, par_bit_q})) != PARITY_ODD);
                        tick_cnt_d   = '0;
                        state_d      = ST_IDLE;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_ONE;
                    end
                end
                default: begin
                    state_d    = ST_IDLE;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            endcase
        end else begin
            state_d = state_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; the synchronous clear mirrors the asynchronous reset.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else if (rst) begin
            state_q      <= ST_IDLE;
            tick_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shreg_q      <= '0;
            par_bit_q    <= 1'b0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tick_cnt_q   <= tick_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shreg_q      <= shreg_d;
            par_bit_q    <= par_bit_d;
            data_out_q   <= data_out_d;
            data_valid_q <= data_valid_d;
            busy_q       <= busy_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign busy       = busy_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Self-checking bench: serial frames are driven tick by tick, expected words are queued
// at send time and compared when data_valid appears.
module tb_uart_rx_deserializer;

    localparam int OS     = 16;
    localparam int TDIV   = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       arst_n;
    logic       rst;
    logic       sample_tick;
    logic       rx_in;
    logic [7:0] data_out;
    logic       data_valid;
    logic       busy;
    logic       parity_err;
    logic       frame_err;

    exp_t exp_q[$];
    int   n_total;
    int   n_bad;

    uart_rx_deserializer #(
        .DATA_BITS  (8),
        .OVERSAMPLE (OS),
        .PARITY_EN  (1'b1),
        .PARITY_ODD (1'b0)
    ) dut (
        .clk         (clk),
        .arst_n      (arst_n),
        .rst         (rst),
        .sample_tick (sample_tick),
        .rx_in       (rx_in),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .busy        (busy),
        .parity_err  (parity_err),
        .frame_err   (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Oversample tick: one clock high out of every TDIV.
    initial begin
        sample_tick = 1'b0;
        forever begin
            repeat (TDIV - 1) begin
                @(negedge clk);
                sample_tick = 1'b0;
            end
            @(negedge clk);
            sample_tick = 1'b1;
        end
    end

    // Scoreboard monitor, sampled away from the active edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (data_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check_val("unexpected_valid", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_val("data_out",   {24'd0, data_out}, {24'd0, e.data});
                    check_val("parity_err", {31'd0, parity_err}, {31'd0, e.perr});
                    check_val("frame_err",  {31'd0, frame_err},  {31'd0, e.ferr});
                    check_val("busy_at_valid", {31'd0, busy}, 32'd0);
                end
            end
        end
    end

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (sample_tick !== 1'b1);
        end
        #1;
    endtask

    function automatic int bit_len(input int idx, input bit jit);
        if (!jit) return OS;
        return (idx % 2 == 1) ? OS + 1 : OS - 1;
    endfunction

    // Full frame: start, 8 data LSB first, parity, stop. Expectation queued up front.
    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic sbit, input bit jit);
        exp_t e;
        e.data = d;
        e.perr = (pbit != ^d);
        e.ferr = ~sbit;
        exp_q.push_back(e);
        rx_in = 1'b0;
        wait_ticks(bit_len(0, jit));
        for (int i = 0; i < 8; i++) begin
            rx_in = d[i];
            wait_ticks(bit_len(i + 1, jit));
        end
        rx_in = pbit;
        wait_ticks(bit_len(9, jit));
        rx_in = sbit;
        wait_ticks(bit_len(10, jit));
        rx_in = 1'b1;
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check_val("drain_pending", exp_q.size(), 32'd0);
    endtask

    // Start a frame, reset it partway through data bit 4, then verify recovery.
    task automatic abort_then_recover(input bit jit);
        logic [7:0] d;
        d = 8'h6B;
        rx_in = 1'b0;
        wait_ticks(bit_len(0, jit));
        for (int i = 0; i < 4; i++) begin
            rx_in = d[i];
            wait_ticks(bit_len(i + 1, jit));
        end
        rx_in = d[4];
        wait_ticks(OS / 2);
        check_val("busy_mid_frame", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_val("rst_busy",     {31'd0, busy},       32'd0);
        check_val("rst_valid",    {31'd0, data_valid}, 32'd0);
        check_val("rst_data_out", {24'd0, data_out},   32'd0);
        rx_in = 1'b1;
        wait_ticks(3 * OS);
        send_frame(8'h81, 1'b0, 1'b1, jit);
        wait_ticks(OS);
        wait_drain();
    endtask

    initial begin
        n_total     = 0;
        n_bad       = 0;
        arst_n      = 1'b0;
        rst         = 1'b0;
        rx_in       = 1'b1;
        repeat (5) @(posedge clk);
        #1 arst_n = 1'b1;
        @(negedge clk);
        check_val("rst_data_out",   {24'd0, data_out},   32'd0);
        check_val("rst_data_valid", {31'd0, data_valid}, 32'd0);
        check_val("rst_busy",       {31'd0, busy},       32'd0);
        check_val("rst_parity_err", {31'd0, parity_err}, 32'd0);
        check_val("rst_frame_err",  {31'd0, frame_err},  32'd0);
        wait_ticks(OS);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        wait_ticks(OS);
        send_frame(8'h3C, 1'b1, 1'b1, 1'b0);
        wait_ticks(OS);
        send_frame(8'h0F, 1'b0, 1'b1, 1'b0);
        wait_ticks(OS);
        send_frame(8'h55, 1'b0, 1'b0, 1'b0);
        wait_ticks(2 * OS);
        check_val("busy_after_ferr", {31'd0, busy}, 32'd0);
        wait_drain();

        // Short low glitch: start is rejected at mid-bit.
        rx_in = 1'b0;
        wait_ticks(2);
        check_val("glitch_busy_hi", {31'd0, busy}, 32'd1);
        wait_ticks(2);
        rx_in = 1'b1;
        wait_ticks(10);
        check_val("glitch_busy_lo", {31'd0, busy}, 32'd0);
        wait_ticks(OS);

        send_frame(8'h01, 1'b1, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b1, 1'b0);
        wait_ticks(OS);
        wait_drain();

        abort_then_recover(1'b0);
        abort_then_recover(1'b1);

        for (int k = 0; k < 4; k++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            send_frame(r, ^r, 1'b1, k[0]);
        end
        wait_ticks(OS);
        wait_drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
